// File: rtl/neuron_layer_pkg.sv
// Shared types and helpers for the neuron layer engine: FSM states,
// register-map address functions, accumulator sizing and saturation.
package neuron_layer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FIN,
        DONE_ST
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_HIGH,
        SAT_LOW
    } sat_dir_t;

    function automatic int weight_addr(input int o, input int i, input int num_inputs);
        return o * num_inputs + i;
    endfunction

    function automatic int bias_addr(input int o, input int num_inputs, input int num_outputs);
        return num_outputs * num_inputs + o;
    endfunction

    function automatic int ctrl_addr(input int num_inputs, input int num_outputs);
        return num_outputs * (num_inputs + 1);
    endfunction

    // Full product width plus enough guard bits to sum every product without wrap.
    function automatic int acc_width(input int width, input int num_inputs);
        return 2 * width + $clog2(num_inputs) + 1;
    endfunction

    function automatic sat_dir_t saturate(input logic signed [63:0] value, input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return SAT_HIGH;
        end else if (value < min_v) begin
            return SAT_LOW;
        end
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed fixed-point multiply-accumulate with bias add, rescale, saturation
// and optional ReLU. Keeps a sticky overflow flag for the current run.
module mac_unit
    import neuron_layer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 5,
    parameter int NUM_INPUTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             acc_en,
    input  logic             fin,
    input  logic [WIDTH-1:0] weight,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] bias,
    input  logic             relu_en,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int ACC_W = acc_width(WIDTH, NUM_INPUTS);

    logic signed [ACC_W-1:0]   acc;
    logic signed [2*WIDTH-1:0] weight_ext;
    logic signed [2*WIDTH-1:0] operand_ext;
    logic signed [2*WIDTH-1:0] product;
    logic signed [ACC_W:0]     biased;
    logic signed [ACC_W:0]     scaled;
    sat_dir_t                  sat_dir;

    // NOTE: every combinational output gets a default at the top so no path
    // through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        weight_ext  = {{WIDTH{weight[WIDTH-1]}}, weight};
        operand_ext = {{WIDTH{operand[WIDTH-1]}}, operand};
        product     = weight_ext * operand_ext;
        biased      = {acc[ACC_W-1], acc}
                    + ({{(ACC_W + 1 - WIDTH){bias[WIDTH-1]}}, bias} <<< FRAC_BITS);
        scaled      = biased >>> FRAC_BITS;
        sat_dir     = saturate({{(63 - ACC_W){scaled[ACC_W]}}, scaled}, WIDTH);
        result      = scaled[WIDTH-1:0];
        case (sat_dir)
            SAT_HIGH: result = {1'b0, {(WIDTH - 1){1'b1}}};
            SAT_LOW:  result = {1'b1, {(WIDTH - 1){1'b0}}};
            default:  result = scaled[WIDTH-1:0];
        endcase
        // ReLU acts on the already-saturated value.
        if (relu_en && result[WIDTH-1]) begin
            result = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear || fin) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + {{(ACC_W - 2 * WIDTH){product[2*WIDTH-1]}}, product};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overflow <= 1'b0;
        end else if (fin && (sat_dir != SAT_NONE)) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/piso_buffer.sv
// Parallel-in serial-out buffer, MSB first, zero fill. A parallel load
// takes priority over a shift in the same cycle.
module piso_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             serial_out
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_en) begin
            data_q <= load_data;
        end else if (shift_en) begin
            data_q <= {data_q[WIDTH-2:0], 1'b0};
        end
    end

    assign serial_out = data_q[WIDTH-1];

endmodule

// File: rtl/sipo_buffer.sv
// Serial-in shift register with a parallel snapshot register, so a new
// vector can be shifted in while the snapshot feeds the datapath.
module sipo_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             snapshot_en,
    output logic [WIDTH-1:0] snapshot
);

    logic [WIDTH-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[WIDTH-2:0], serial_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot <= '0;
        end else if (snapshot_en) begin
            snapshot <= shift_q;
        end
    end

endmodule

// File: rtl/neuron_layer_engine.sv
// Fully-connected layer engine: time-multiplexes one MAC over NUM_OUTPUTS
// neurons, with serial operand load, register-file parameters and serial results.
module neuron_layer_engine
    import neuron_layer_pkg::*;
#(
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_OUTPUTS = 2,
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 5,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WREQ,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [WIDTH-1:0]      WDATA,
    output logic                  WACK,
    input  logic                  LOAD_IN,
    input  logic                  LOAD_VALUE_IN,
    input  logic                  SHIFT_OUT,
    output logic                  SHIFT_VALUE_OUT,
    output logic                  READY,
    input  logic                  START,
    output logic                  DONE,
    output logic                  OVERFLOW
);

    localparam int IN_IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int OUT_IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    state_t                 state;
    state_t                 next_state;
    logic [IN_IDX_W-1:0]    in_idx;
    logic [OUT_IDX_W-1:0]   out_idx;
    logic                   in_last;
    logic                   out_last;
    logic                   start_accept;

    logic [WIDTH-1:0]       weights [NUM_OUTPUTS][NUM_INPUTS];
    logic [WIDTH-1:0]       biases  [NUM_OUTPUTS];
    logic                   relu_en;
    logic [WIDTH-1:0]       results [NUM_OUTPUTS];

    logic [NUM_INPUTS*WIDTH-1:0]  operands;
    logic [NUM_OUTPUTS*WIDTH-1:0] out_word;
    logic [WIDTH-1:0]             cur_operand;
    logic [WIDTH-1:0]             mac_result;

    assign in_last  = (in_idx == IN_IDX_W'(NUM_INPUTS - 1));
    assign out_last = (out_idx == OUT_IDX_W'(NUM_OUTPUTS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        READY        = 1'b0;
        DONE         = 1'b0;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                READY        = 1'b1;
                start_accept = START;
                if (START) begin
                    next_state = MAC;
                end
            end
            MAC: begin
                if (in_last) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = out_last ? DONE_ST : MAC;
            end
            DONE_ST: begin
                DONE       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_idx  <= '0;
            out_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        in_idx  <= '0;
                        out_idx <= '0;
                    end
                end
                MAC:     in_idx  <= in_last ? '0 : in_idx + IN_IDX_W'(1);
                FIN:     out_idx <= out_idx + OUT_IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            WACK <= 1'b0;
        end else begin
            WACK <= WREQ;
        end
    end

    // NOTE: the register file is small and must read as zero after reset, so
    // it is built from resettable flops rather than an inferred RAM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    weights[o][i] <= '0;
                end
                biases[o] <= '0;
            end
            relu_en <= 1'b0;
        end else if (WREQ && (state == IDLE)) begin
            // Unmapped addresses match nothing below and are dropped.
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (WADDR == ADDR_WIDTH'(weight_addr(o, i, NUM_INPUTS))) begin
                        weights[o][i] <= WDATA;
                    end
                end
                if (WADDR == ADDR_WIDTH'(bias_addr(o, NUM_INPUTS, NUM_OUTPUTS))) begin
                    biases[o] <= WDATA;
                end
            end
            if (WADDR == ADDR_WIDTH'(ctrl_addr(NUM_INPUTS, NUM_OUTPUTS))) begin
                relu_en <= WDATA[0];
            end
        end
    end

    sipo_buffer #(
        .WIDTH(NUM_INPUTS * WIDTH)
    ) u_in_buf (
        .clk        (CLK),
        .rst        (RST),
        .shift_en   (LOAD_IN),
        .serial_in  (LOAD_VALUE_IN),
        .snapshot_en(start_accept),
        .snapshot   (operands)
    );

    assign cur_operand = operands[in_idx*WIDTH +: WIDTH];

    mac_unit #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .NUM_INPUTS(NUM_INPUTS)
    ) u_mac (
        .clk     (CLK),
        .rst     (RST),
        .clear   (start_accept),
        .acc_en  (state == MAC),
        .fin     (state == FIN),
        .weight  (weights[out_idx][in_idx]),
        .operand (cur_operand),
        .bias    (biases[out_idx]),
        .relu_en (relu_en),
        .result  (mac_result),
        .overflow(OVERFLOW)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                results[o] <= '0;
            end
        end else if (state == FIN) begin
            results[out_idx] <= mac_result;
        end
    end

    // result[0] occupies the top word so it leaves the serial port first.
    always_comb begin
        out_word = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            out_word[(NUM_OUTPUTS-1-o)*WIDTH +: WIDTH] = results[o];
        end
    end

    piso_buffer #(
        .WIDTH(NUM_OUTPUTS * WIDTH)
    ) u_out_buf (
        .clk       (CLK),
        .rst       (RST),
        .load_en   (state == DONE_ST),
        .load_data (out_word),
        .shift_en  (SHIFT_OUT),
        .serial_out(SHIFT_VALUE_OUT)
    );

endmodule

// File: tb/tb_neuron_layer_engine.sv
// Directed self-checking bench for neuron_layer_engine at 2 inputs x 2 outputs,
// Q2.5 arithmetic (1.0 = 0x20).
module tb_neuron_layer_engine;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WREQ = 1'b0;
    logic [3:0] WADDR = '0;
    logic [7:0] WDATA = '0;
    logic       WACK;
    logic       LOAD_IN = 1'b0;
    logic       LOAD_VALUE_IN = 1'b0;
    logic       SHIFT_OUT = 1'b0;
    logic       SHIFT_VALUE_OUT;
    logic       READY;
    logic       START = 1'b0;
    logic       DONE;
    logic       OVERFLOW;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    neuron_layer_engine #(
        .NUM_INPUTS (2),
        .NUM_OUTPUTS(2),
        .WIDTH      (8),
        .FRAC_BITS  (5),
        .ADDR_WIDTH (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .WREQ           (WREQ),
        .WADDR          (WADDR),
        .WDATA          (WDATA),
        .WACK           (WACK),
        .LOAD_IN        (LOAD_IN),
        .LOAD_VALUE_IN  (LOAD_VALUE_IN),
        .SHIFT_OUT      (SHIFT_OUT),
        .SHIFT_VALUE_OUT(SHIFT_VALUE_OUT),
        .READY          (READY),
        .START          (START),
        .DONE           (DONE),
        .OVERFLOW       (OVERFLOW)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [7:0] data);
        WREQ  = 1'b1;
        WADDR = addr;
        WDATA = data;
        tick();
        WREQ  = 1'b0;
    endtask

    // Element 1 goes in first, MSB first.
    task automatic load_vector(input logic [7:0] x0, input logic [7:0] x1);
        logic [15:0] vec;
        vec = {x1, x0};
        for (int b = 15; b >= 0; b--) begin
            LOAD_IN       = 1'b1;
            LOAD_VALUE_IN = vec[b];
            tick();
        end
        LOAD_IN       = 1'b0;
        LOAD_VALUE_IN = 1'b0;
    endtask

    // Returns in the DONE cycle; latency counts cycles after the START edge.
    task automatic run(output int latency);
        START = 1'b1;
        tick();
        START   = 1'b0;
        latency = 1;
        while (DONE !== 1'b1 && latency < 40) begin
            tick();
            latency++;
        end
    endtask

    task automatic read_out(output logic [7:0] r0, output logic [7:0] r1);
        logic [15:0] s;
        for (int b = 15; b >= 0; b--) begin
            s[b]      = SHIFT_VALUE_OUT;
            SHIFT_OUT = 1'b1;
            tick();
        end
        SHIFT_OUT = 1'b0;
        r0 = s[15:8];
        r1 = s[7:0];
    endtask

    task automatic write_basic();
        write_reg(4'd0, 8'h10);
        write_reg(4'd1, 8'h20);
        write_reg(4'd2, 8'hE0);
        write_reg(4'd3, 8'h00);
        write_reg(4'd4, 8'h08);
        write_reg(4'd5, 8'h00);
        write_reg(4'd6, 8'h00);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", READY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
        checks++; if (WACK !== 1'b0) begin errors++; $display("FAIL reset_wack: got %b expected 0", WACK); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", OVERFLOW); end
        checks++; if (SHIFT_VALUE_OUT !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b expected 0", SHIFT_VALUE_OUT); end
    endtask

    task automatic test_basic();
        int lat;
        logic [7:0] r0, r1;
        write_basic();
        checks++; if (WACK !== 1'b1) begin errors++; $display("FAIL basic_wack: got %b expected 1", WACK); end
        write_reg(4'd7, 8'h01);
        checks++; if (WACK !== 1'b1) begin errors++; $display("FAIL unmapped_wack: got %b expected 1", WACK); end
        write_reg(4'd15, 8'h01);
        load_vector(8'h20, 8'h10);
        run(lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency: got %0d expected 7", lat); end
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b expected 0", READY); end
        tick();
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", READY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", DONE); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", OVERFLOW); end
        read_out(r0, r1);
        checks++; if (r0 !== 8'h28) begin errors++; $display("FAIL basic_result0: got %h expected 28", r0); end
        checks++; if (r1 !== 8'hE0) begin errors++; $display("FAIL basic_result1: got %h expected e0", r1); end
    endtask

    task automatic test_relu();
        int lat;
        logic [7:0] r0, r1;
        write_reg(4'd6, 8'h01);
        run(lat);
        tick();
        read_out(r0, r1);
        checks++; if (r0 !== 8'h28) begin errors++; $display("FAIL relu_result0: got %h expected 28", r0); end
        checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL relu_result1: got %h expected 00", r1); end
        write_reg(4'd6, 8'h00);
    endtask

    task automatic test_saturation();
        int lat;
        logic [7:0] r0, r1;
        for (int a = 0; a < 4; a++) write_reg(4'(a), 8'h7F);
        write_reg(4'd4, 8'h00);
        write_reg(4'd5, 8'h00);
        load_vector(8'h7F, 8'h7F);
        run(lat);
        tick();
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL sat_hi_overflow: got %b expected 1", OVERFLOW); end
        read_out(r0, r1);
        checks++; if (r0 !== 8'h7F) begin errors++; $display("FAIL sat_hi_result0: got %h expected 7f", r0); end
        checks++; if (r1 !== 8'h7F) begin errors++; $display("FAIL sat_hi_result1: got %h expected 7f", r1); end

        load_vector(8'h01, 8'h01);
        run(lat);
        tick();
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL sat_clear_overflow: got %b expected 0", OVERFLOW); end
        read_out(r0, r1);
        checks++; if (r0 !== 8'h07) begin errors++; $display("FAIL small_result0: got %h expected 07", r0); end
        checks++; if (r1 !== 8'h07) begin errors++; $display("FAIL small_result1: got %h expected 07", r1); end

        for (int a = 0; a < 4; a++) write_reg(4'(a), 8'h80);
        load_vector(8'h7F, 8'h7F);
        run(lat);
        tick();
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL sat_lo_overflow: got %b expected 1", OVERFLOW); end
        read_out(r0, r1);
        checks++; if (r0 !== 8'h80) begin errors++; $display("FAIL sat_lo_result0: got %h expected 80", r0); end
        checks++; if (r1 !== 8'h80) begin errors++; $display("FAIL sat_lo_result1: got %h expected 80", r1); end
    endtask

    // Run on A while shifting in B, with a busy write and a busy START.
    task automatic test_back_to_back();
        int lat;
        logic [7:0] r0, r1;
        logic [15:0] vec_b;
        vec_b = 16'h2010;
        write_basic();
        load_vector(8'h20, 8'h10);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c <= 8) begin
                checks++;
                if (DONE !== (c == 7)) begin errors++; $display("FAIL busy_done_timing: cycle %0d got %b expected %b", c, DONE, (c == 7)); end
            end
            if (c == 3) begin
                checks++; if (WACK !== 1'b1) begin errors++; $display("FAIL busy_wack: got %b expected 1", WACK); end
            end
            if (c == 8) begin
                checks++; if (READY !== 1'b1) begin errors++; $display("FAIL busy_ready_after: got %b expected 1", READY); end
            end
            LOAD_IN       = 1'b1;
            LOAD_VALUE_IN = vec_b[16-c];
            WREQ          = (c == 2);
            WADDR         = 4'd0;
            WDATA         = 8'h7F;
            START         = (c == 4);
            tick();
        end
        LOAD_IN = 1'b0;
        WREQ    = 1'b0;
        START   = 1'b0;
        read_out(r0, r1);
        checks++; if (r0 !== 8'h28) begin errors++; $display("FAIL b2b_first_result0: got %h expected 28", r0); end
        checks++; if (r1 !== 8'hE0) begin errors++; $display("FAIL b2b_first_result1: got %h expected e0", r1); end
        run(lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL b2b_latency: got %0d expected 7", lat); end
        tick();
        read_out(r0, r1);
        checks++; if (r0 !== 8'h30) begin errors++; $display("FAIL b2b_second_result0: got %h expected 30", r0); end
        checks++; if (r1 !== 8'hF0) begin errors++; $display("FAIL b2b_second_result1: got %h expected f0", r1); end
    endtask

    task automatic test_shift_in_done();
        int lat;
        logic [7:0] r0, r1;
        write_reg(4'd0, 8'hE0);
        write_reg(4'd1, 8'h00);
        write_reg(4'd2, 8'h10);
        write_reg(4'd3, 8'h20);
        write_reg(4'd4, 8'h00);
        write_reg(4'd5, 8'h08);
        run(lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL shiftdone_latency: got %0d expected 7", lat); end
        SHIFT_OUT = 1'b1;
        tick();
        SHIFT_OUT = 1'b0;
        checks++; if (SHIFT_VALUE_OUT !== 1'b1) begin errors++; $display("FAIL shiftdone_first_bit: got %b expected 1", SHIFT_VALUE_OUT); end
        read_out(r0, r1);
        checks++; if (r0 !== 8'hF0) begin errors++; $display("FAIL shiftdone_result0: got %h expected f0", r0); end
        checks++; if (r1 !== 8'h30) begin errors++; $display("FAIL shiftdone_result1: got %h expected 30", r1); end
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic saw_done;
        logic [7:0] r0, r1;
        run(lat);
        tick();
        checks++; if (SHIFT_VALUE_OUT !== 1'b1) begin errors++; $display("FAIL midrst_pre_sout: got %b expected 1", SHIFT_VALUE_OUT); end
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        RST   = 1'b1;
        WREQ  = 1'b1;
        WADDR = 4'd0;
        WDATA = 8'h55;
        tick();
        RST  = 1'b0;
        WREQ = 1'b0;
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", READY); end
        checks++; if (WACK !== 1'b0) begin errors++; $display("FAIL midrst_wack: got %b expected 0", WACK); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", DONE); end
        checks++; if (SHIFT_VALUE_OUT !== 1'b0) begin errors++; $display("FAIL midrst_sout: got %b expected 0", SHIFT_VALUE_OUT); end
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b expected 0", OVERFLOW); end
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (DONE === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b expected 0", saw_done); end
        write_basic();
        load_vector(8'h20, 8'h10);
        run(lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL midrst_latency: got %0d expected 7", lat); end
        tick();
        read_out(r0, r1);
        checks++; if (r0 !== 8'h28) begin errors++; $display("FAIL midrst_result0: got %h expected 28", r0); end
        checks++; if (r1 !== 8'hE0) begin errors++; $display("FAIL midrst_result1: got %h expected e0", r1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_back_to_back();
        test_shift_in_done();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
